// File: rtl/cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_pkg : shared encodings for the cache fill arbiter
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_DCACHE = 2'd1,
    OWN_ICACHE = 2'd2
  } owner_t;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & BLOCK_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_fill_arbiter : shares one memory port between D-cache stores and
//                      D/I-cache block fills (fixed priority, no preemption)
// Revision           : 1.0 - initial release
// ---------------------------------------------------------------------------
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY     = 4,   // must be >= 1
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dstore_req,
  input  logic [15:0] dstore_addr,
  input  logic [15:0] dstore_data,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic [15:0] fill_word,
  output logic [2:0]  fill_idx,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        dstore_ack,
  output logic        busy
);

  localparam int              CNT_W    = $clog2(WORDS_PER_BLOCK + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

  state_t                 r_state;
  owner_t                 r_owner;
  logic [15:0]            r_base;
  logic [CNT_W-1:0]       r_issue_cnt;
  logic [CNT_W-1:0]       r_recv_cnt;
  logic [MEM_LATENCY-1:0] r_rd_pipe;

  logic w_fill_active;
  logic w_last_beat;
  logic w_rd_issue;

  // Beats are only accepted when a read issued by this fill is due back, so
  // beats still in flight from before a reset can never reach a cache.
  assign w_rd_issue    = mem_en & ~mem_wr;
  assign w_fill_active = mem_data_valid & r_rd_pipe[MEM_LATENCY-1] &
                         ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_last_beat   = w_fill_active && (r_recv_cnt == LAST_IDX);

  assign fill_word      = w_fill_active ? mem_rdata : 16'h0000;
  assign fill_idx       = w_fill_active ? 3'(r_recv_cnt) : 3'd0;
  assign dcache_fill_we = w_fill_active && (r_owner == OWN_DCACHE);
  assign icache_fill_we = w_fill_active && (r_owner == OWN_ICACHE);
  assign busy           = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_owner          <= OWN_NONE;
      r_base           <= 16'h0000;
      r_issue_cnt      <= '0;
      r_recv_cnt       <= '0;
      r_rd_pipe        <= '0;
      mem_en           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_addr         <= 16'h0000;
      mem_wdata        <= 16'h0000;
      dstore_ack       <= 1'b0;
      icache_fill_done <= 1'b0;
      dcache_fill_done <= 1'b0;
    end else begin
      r_rd_pipe        <= MEM_LATENCY'({r_rd_pipe, w_rd_issue});
      dstore_ack       <= 1'b0;
      icache_fill_done <= 1'b0;
      dcache_fill_done <= 1'b0;
      if (w_fill_active) begin
        r_recv_cnt <= r_recv_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (dstore_req) begin
            mem_en     <= 1'b1;
            mem_wr     <= 1'b1;
            mem_addr   <= dstore_addr;
            mem_wdata  <= dstore_data;
            dstore_ack <= 1'b1;
            r_state    <= ST_STORE;
          end else if (dcache_miss || icache_miss) begin
            r_owner     <= dcache_miss ? OWN_DCACHE : OWN_ICACHE;
            r_base      <= block_base(dcache_miss ? dcache_miss_addr : icache_miss_addr);
            mem_en      <= 1'b1;
            mem_wr      <= 1'b0;
            mem_addr    <= block_base(dcache_miss ? dcache_miss_addr : icache_miss_addr);
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= ST_ISSUE;
          end
        end

        ST_STORE: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= 16'h0000;
          mem_wdata <= 16'h0000;
          r_state   <= ST_IDLE;
        end

        ST_ISSUE: begin
          if (r_issue_cnt == LAST_IDX) begin
            mem_en   <= 1'b0;
            mem_addr <= 16'h0000;
            if (w_last_beat) begin
              dcache_fill_done <= (r_owner == OWN_DCACHE);
              icache_fill_done <= (r_owner == OWN_ICACHE);
              r_state          <= ST_DONE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            mem_addr    <= r_base + 16'({r_issue_cnt + CNT_W'(1), 1'b0});
          end
        end

        ST_DRAIN: begin
          if (w_last_beat) begin
            dcache_fill_done <= (r_owner == OWN_DCACHE);
            icache_fill_done <= (r_owner == OWN_ICACHE);
            r_state          <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_owner <= OWN_NONE;
          r_state <= ST_IDLE;
        end

        default: begin
          mem_en  <= 1'b0;
          mem_wr  <= 1'b0;
          r_owner <= OWN_NONE;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
